seg7_scan_driver: RTL and testbench

Parametrised multiplexed seven-segment scan driver for DIGITS hex digits, each with a decimal point and per-digit blanking. Sits between application logic and the board's common-anode display pins. A shadow-register handshake updates the display only on frame boundaries, so the display never tears. Anode PWM gives digital brightness control.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_hex_decode.sv | 14 +
 rtl/seg7_scan_driver.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and segment decoding for the seven-segment scan driver.
// Segment vectors are ordered {a,b,c,d,e,f,g}, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,  // 0 1 2 3
    7'h4C, 7'h24, 7'h20, 7'h0F,  // 4 5 6 7
    7'h00, 7'h04, 7'h08, 7'h60,  // 8 9 A b
    7'h31, 7'h42, 7'h30, 7'h38   // C d E F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low segment pattern {a..g}.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [0:6] seg
);

  // Pure table lookup; seg[0] is segment a.
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver with frame-synchronous shadow update
// and anode PWM brightness. Common-anode display, all outputs active-low.
// Optional macro LZ_BLANK_EN: leading-zero suppression on the active value.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned SCAN_BITS = 17,
  parameter int unsigned PWM_BITS  = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [4*DIGITS-1:0]   text,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IDX_BITS = $clog2(DIGITS);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(DIGITS - 1);

  logic [SCAN_BITS-1:0] cnt;
  logic [IDX_BITS-1:0]  idx;
  logic                 tick;
  logic                 boundary;
  logic [PWM_BITS-1:0]  phase;

  logic [4*DIGITS-1:0]  stg_text, act_text;
  logic [DIGITS-1:0]    stg_dp, act_dp;
  logic [DIGITS-1:0]    stg_blank, act_blank;

  logic [DIGITS-1:0]    suppress;
  logic [3:0]           cur_nib;
  logic [0:6]           dec_seg;
  logic                 lit;
  logic [DIGITS-1:0]    an_nxt;
  logic [0:6]           seg_nxt;
  logic                 dp_nxt;

  assign tick     = &cnt;
  assign boundary = tick && (idx == LAST_IDX);
  assign phase    = cnt[SCAN_BITS-1 -: PWM_BITS];

  // Free-running prescaler and digit index.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (tick) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

  // Shadow handshake: a load landing on the boundary bypasses staging and
  // supersedes any pending value, so at most one transfer happens per frame.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      stg_text  <= '0;
      stg_dp    <= '0;
      stg_blank <= '0;
      act_text  <= '0;
      act_dp    <= '0;
      act_blank <= '0;
      busy      <= 1'b0;
    end else if (boundary) begin
      busy <= 1'b0;
      if (load) begin
        act_text  <= text;
        act_dp    <= dp_in;
        act_blank <= blank;
      end else if (busy) begin
        act_text  <= stg_text;
        act_dp    <= stg_dp;
        act_blank <= stg_blank;
      end
    end else if (load) begin
      stg_text  <= text;
      stg_dp    <= dp_in;
      stg_blank <= blank;
      busy      <= 1'b1;
    end
  end

`ifdef LZ_BLANK_EN
  // Leading-zero suppression: walk from the top digit down while nibbles are zero.
  always_comb begin
    logic zero_run;
    int unsigned i;
    suppress = '0;
    zero_run = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      i = DIGITS - 1 - k;
      zero_run = zero_run && (act_text[4*i +: 4] == 4'h0);
      if (i != 0) begin
        suppress[i] = zero_run;
      end
    end
  end
`else
  // No suppression in this build.
  always_comb begin
    suppress = '0;
  end
`endif

  seg7_hex_decode u_hex_decode (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  // Select the current digit and decide whether its anode is driven this cycle.
  always_comb begin
    cur_nib = act_text[4*int'(idx) +: 4];
    lit     = (phase < brightness) && !act_blank[idx] && !suppress[idx];
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (lit) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = dec_seg;
      dp_nxt      = ~act_dp[idx];
    end
  end

  // Registered pin drivers and frame pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      an         <= '1;
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= boundary;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver (DIGITS=4, SCAN_BITS=4, PWM_BITS=2).
// Reference model works from elapsed cycle count: slot = t/16, phase = (t%16)/4.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        arst;
  logic [15:0] text;
  logic [3:0]  dp_in;
  logic [3:0]  blank;
  logic        load;
  logic [1:0]  brightness;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        busy;
  logic        frame_done;

  seg7_scan_driver #(
    .DIGITS    (4),
    .SCAN_BITS (4),
    .PWM_BITS  (2)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .text       (text),
    .dp_in      (dp_in),
    .blank      (blank),
    .load       (load),
    .brightness (brightness),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Segments lit (active-high) for 0..F, ordered {a..g}.
  localparam logic [6:0] SEG_LIT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          t;
  logic [15:0] m_text, m_stext;
  logic [3:0]  m_dp, m_sdp, m_blank, m_sblank;
  bit          m_pend;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp, exp_busy, exp_fd;
  int          md, mph;
  bit          mdark, mbnd;
  logic [3:0]  mnib;

  function automatic bit lz_dark(input logic [15:0] v, input int d);
`ifdef LZ_BLANK_EN
    return (d != 0) && ((v >> (4*d)) == 16'h0);
`else
    return (v === 16'hxxxx) && (d < 0);
`endif
  endfunction

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      t = 0;
      m_text = '0; m_dp = '0; m_blank = '0;
      m_stext = '0; m_sdp = '0; m_sblank = '0;
      m_pend = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      exp_busy = 1'b0; exp_fd = 1'b0;
    end else begin
      md    = (t / 16) % 4;
      mph   = (t % 16) / 4;
      mbnd  = (t % 64) == 63;
      mnib  = 4'((m_text >> (4*md)) & 16'hF);
      mdark = m_blank[md] || (mph >= int'(brightness)) || lz_dark(m_text, md);
      exp_an  = mdark ? 4'hF : ~(4'b0001 << md);
      exp_seg = mdark ? 7'h7F : ~SEG_LIT[mnib];
      exp_dp  = mdark ? 1'b1 : ~m_dp[md];
      exp_fd  = mbnd;
      if (mbnd) begin
        if (load) begin
          m_text = text; m_dp = dp_in; m_blank = blank;
        end else if (m_pend) begin
          m_text = m_stext; m_dp = m_sdp; m_blank = m_sblank;
        end
        m_pend = 0;
      end else if (load) begin
        m_stext = text; m_sdp = dp_in; m_sblank = blank;
        m_pend = 1;
      end
      exp_busy = m_pend;
      t++;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("an", an, exp_an);
      check("seg", seg, exp_seg);
      check("dp", dp, exp_dp);
      check("busy", busy, exp_busy);
      check("frame_done", frame_done, exp_fd);
      check("an_onehot", ($countones(~an) <= 1), 1);
    end
  end

  // ---------------- directed helpers ----------------
  int         lit_cnt [4];
  logic [6:0] seen_seg [4];
  int         fd_cnt, busy_falls, busy_hi, bad_cnt;
  logic       prev_busy;

  task automatic wait_t(input int m);
    int n = 0;
    @(negedge clk);
    while ((t % 64) != m && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("wait_t_timeout", 1, 0);
  endtask

  task automatic do_load(input logic [15:0] tx, input logic [3:0] dv, input logic [3:0] bv);
    text = tx; dp_in = dv; blank = bv; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Observe 64 cycles, tallying lit cycles and last pattern per digit.
  task automatic scan(input int cycles);
    for (int d = 0; d < 4; d++) begin
      lit_cnt[d] = 0;
      seen_seg[d] = 7'h7F;
    end
    fd_cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (an == ~(4'b0001 << d)) begin
          lit_cnt[d]++;
          seen_seg[d] = seg;
        end
      end
      if (frame_done) fd_cnt++;
      if (prev_busy && !busy) busy_falls++;
      if (busy) busy_hi++;
      if ((an == 4'b0111 && seg == 7'h4F) || (an == 4'b1011 && seg == 7'h12) ||
          (an == 4'b1101 && seg == 7'h06) || (an == 4'b1110 && seg == 7'h4C)) bad_cnt++;
      prev_busy = busy;
    end
  endtask

  initial begin
    arst = 1'b1; text = '0; dp_in = '0; blank = '0; load = 1'b0; brightness = 2'd3;
    prev_busy = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    arst = 1'b0;
    chk_en = 1;

    // Basic load and one full frame of display.
    wait_t(10);
    do_load(16'h8602, 4'h0, 4'h0);
    check("busy_rise", busy, 1'b1);
    wait_t(0);
    check("busy_fell", busy, 1'b0);
    scan(64);
    for (int d = 0; d < 4; d++) check("lit12", lit_cnt[d], 12);
    check("seg_d0", seen_seg[0], 7'h12);
    check("seg_d1", seen_seg[1], 7'h01);
    check("seg_d2", seen_seg[2], 7'h20);
    check("seg_d3", seen_seg[3], 7'h00);
    check("fd_per_frame", fd_cnt, 1);
    check("fd_at_64", frame_done, 1'b1);

    // Two loads before a boundary: only the second is ever shown.
    wait_t(5);
    do_load(16'h1234, 4'h0, 4'h0);
    repeat (2) @(negedge clk);
    do_load(16'hABCD, 4'h0, 4'h0);
    prev_busy = busy; busy_falls = 0; bad_cnt = 0;
    scan(64);
    scan(64);
    check("double_load_falls", busy_falls, 1);
    check("double_load_never1234", bad_cnt, 0);
    check("abcd_d0", seen_seg[0], 7'h42);
    check("abcd_d3", seen_seg[3], 7'h08);

    // Load exactly on the boundary goes straight to active.
    wait_t(63);
    do_load(16'h7E3C, 4'h0, 4'h0);
    check("bypass_busy", busy, 1'b0);
    prev_busy = busy; busy_hi = 0; busy_falls = 0;
    scan(64);
    check("bypass_busy_hi", busy_hi, 0);
    check("bypass_d0", seen_seg[0], 7'h31);
    check("bypass_d1", seen_seg[1], 7'h06);
    check("bypass_d2", seen_seg[2], 7'h30);
    check("bypass_d3", seen_seg[3], 7'h0F);

    // Brightness zero and per-digit blank.
    brightness = 2'd0;
    @(negedge clk);
    scan(64);
    check("dark_total", lit_cnt[0] + lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
    brightness = 2'd3;
    wait_t(20);
    do_load(16'h4321, 4'b0001, 4'b0100);
    wait_t(0);
    scan(64);
    check("blank_d2", lit_cnt[2], 0);
    check("blank_d0", lit_cnt[0], 12);
    check("blank_d1", lit_cnt[1], 12);
    check("blank_d3", lit_cnt[3], 12);

`ifdef LZ_BLANK_EN
    wait_t(20);
    do_load(16'h0050, 4'h0, 4'h0);
    wait_t(0);
    scan(64);
    check("lz_d3", lit_cnt[3], 0);
    check("lz_d2", lit_cnt[2], 0);
    check("lz_d1", seen_seg[1], 7'h24);
    check("lz_d0", seen_seg[0], 7'h01);
    wait_t(20);
    do_load(16'h0000, 4'h0, 4'h0);
    wait_t(0);
    scan(64);
    check("lz0_d0", lit_cnt[0], 12);
    check("lz0_d0seg", seen_seg[0], 7'h01);
    check("lz0_rest", lit_cnt[1] + lit_cnt[2] + lit_cnt[3], 0);
`endif

    // Randomised traffic checked by the model.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        text = 16'($urandom); dp_in = 4'($urandom); blank = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 29) == 0) brightness = 2'($urandom);
      @(negedge clk);
    end
    load = 1'b0;

    // Asynchronous reset mid-frame discards a pending load.
    brightness = 2'd3;
    wait_t(30);
    do_load(16'hFFFF, 4'h0, 4'h0);
    check("pre_rst_busy", busy, 1'b1);
    #2 arst = 1'b1;
    #1;
    check("arst_an", an, 4'hF);
    check("arst_seg", seg, 7'h7F);
    check("arst_busy", busy, 1'b0);
    @(negedge clk);
    arst = 1'b0;
    repeat (70) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
